// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receive front-end: synchronises rx_serial, majority-votes each bit at its centre
// and hands completed bytes downstream over valid/ready, with frame and overrun error strobes.
module uart_rx_deserializer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  uart_clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    input  logic                  enable,
    input  logic                  rx_serial,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_error,
    output logic                  overrun_error,
    output logic                  rx_active
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] CNT_POST = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBrk} state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [1:0]             samp_q, samp_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   vote;
    logic                   deliver;

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    // Third sample is the live rx_s on the tick where cnt == MID+1.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (sample_tick) begin
            if (state_q != StIdle && state_q != StBrk) begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_PRE) samp_d[0] = rx_s;
                if (cnt_q == CNT_MID) samp_d[1] = rx_s;
            end
            case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end
                end
                StStart: begin
                    if (cnt_q == CNT_POST && vote) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = StData;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end
                StData: begin
                    if (cnt_q == CNT_POST) shift_d = DATA_WIDTH'({vote, shift_q} >> 1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) state_d = StStop;
                        else                   idx_d   = idx_q + IDX_ONE;
                    end
                end
                StStop: begin
                    // Leave at the stop-bit centre so the next start edge is caught promptly.
                    if (cnt_q == CNT_POST) begin
                        cnt_d = '0;
                        if (vote) begin
                            deliver = 1'b1;
                            state_d = StIdle;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = StBrk;
                        end
                    end
                end
                StBrk: begin
                    if (rx_s) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = 1'b0;
        if (valid_q && out_ready) valid_d = 1'b0;
        if (deliver) begin
            if (!valid_q || out_ready) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            samp_q      <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data      = data_q;
    assign out_valid     = valid_q;
    assign frame_error   = frame_err_q;
    assign overrun_error = overrun_q;
    assign rx_active     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: ticks every 4th clock, 16x oversampling, 8N1 frames.
module tb_uart_rx_deserializer;

    logic       uart_clk = 1'b0;
    logic       rst_n;
    logic       sample_tick = 1'b0;
    logic       enable;
    logic       rx_serial;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_error;
    logic       overrun_error;
    logic       rx_active;

    int vectors     = 0;
    int miscompares = 0;

    int   vrise = 0, vhigh = 0, fe_cnt = 0, ov_cnt = 0, act_cnt = 0, stab_err = 0;
    logic prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00, last_d = 8'h00;
    int   v0, h0, f0, o0, a0;

    uart_rx_deserializer #(
        .DATA_WIDTH (8),
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .uart_clk     (uart_clk),
        .rst_n        (rst_n),
        .sample_tick  (sample_tick),
        .enable       (enable),
        .rx_serial    (rx_serial),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .frame_error  (frame_error),
        .overrun_error(overrun_error),
        .rx_active    (rx_active)
    );

    initial forever #5 uart_clk = ~uart_clk;

    // Tick is high across exactly one rising edge out of every four.
    initial forever begin
        repeat (3) @(negedge uart_clk);
        sample_tick = 1'b1;
        @(negedge uart_clk);
        sample_tick = 1'b0;
    end

    always @(negedge uart_clk) begin
        prev_v <= out_valid;
        prev_r <= out_ready;
        prev_d <= out_data;
        if (out_valid && !prev_v) begin
            vrise  <= vrise + 1;
            last_d <= out_data;
        end
        if (out_valid) vhigh <= vhigh + 1;
        fe_cnt <= fe_cnt + int'(frame_error);
        ov_cnt <= ov_cnt + int'(overrun_error);
        if (rx_active) act_cnt <= act_cnt + 1;
        if (prev_v && !prev_r && out_data !== prev_d) stab_err <= stab_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge sample_tick);
    endtask

    task automatic send_bit(input logic v, input int n);
        rx_serial = v;
        ticks(n);
    endtask

    task automatic send_data(input logic [7:0] d);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_data(d);
        send_bit(1'b1, 16);
        rx_serial = 1'b1;
    endtask

    task automatic snap();
        v0 = vrise; h0 = vhigh; f0 = fe_cnt; o0 = ov_cnt; a0 = act_cnt;
    endtask

    initial begin
        logic [7:0] d;
        rst_n     = 1'b0;
        enable    = 1'b1;
        rx_serial = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge uart_clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_fe", 32'(frame_error), 32'd0);
        check("rst_ov", 32'(overrun_error), 32'd0);
        check("rst_active", 32'(rx_active), 32'd0);
        rst_n = 1'b1;
        ticks(4);

        // Clean 0x55 with the consumer always ready.
        snap();
        send_frame(8'h55);
        ticks(8);
        check("t1_vrise", 32'(vrise - v0), 32'd1);
        check("t1_data", 32'(last_d), 32'h55);
        check("t1_vhigh", 32'(vhigh - h0), 32'd1);
        check("t1_fe", 32'(fe_cnt - f0), 32'd0);
        check("t1_ov", 32'(ov_cnt - o0), 32'd0);
        check("t1_valid_low", 32'(out_valid), 32'd0);

        // Short low pulse rejected at the start-bit vote.
        snap();
        send_bit(1'b0, 4);
        rx_serial = 1'b1;
        ticks(24);
        check("t2_active_seen", 32'(act_cnt > a0), 32'd1);
        check("t2_vrise", 32'(vrise - v0), 32'd0);
        check("t2_fe", 32'(fe_cnt - f0), 32'd0);
        check("t2_idle", 32'(rx_active), 32'd0);

        // Low stop bit followed by a held break.
        snap();
        send_data(8'hA3);
        send_bit(1'b0, 40);
        check("t3_brk_active", 32'(rx_active), 32'd1);
        check("t3_fe", 32'(fe_cnt - f0), 32'd1);
        check("t3_vrise", 32'(vrise - v0), 32'd0);
        rx_serial = 1'b1;
        ticks(4);
        check("t3_idle", 32'(rx_active), 32'd0);

        // Back-to-back bytes into a stalled consumer.
        out_ready = 1'b0;
        snap();
        send_frame(8'h12);
        send_frame(8'h34);
        ticks(8);
        check("t4_valid", 32'(out_valid), 32'd1);
        check("t4_data", 32'(out_data), 32'h12);
        check("t4_ov", 32'(ov_cnt - o0), 32'd1);
        check("t4_fe", 32'(fe_cnt - f0), 32'd0);
        check("t4_vrise", 32'(vrise - v0), 32'd1);
        out_ready = 1'b1;
        @(negedge uart_clk);
        check("t4_valid_drop", 32'(out_valid), 32'd0);

        // 0x0F with a one-tick inverted glitch at the centre of bit 2.
        snap();
        d = 8'h0F;
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                send_bit(d[i], 9);
                send_bit(~d[i], 1);
                send_bit(d[i], 6);
            end else begin
                send_bit(d[i], 16);
            end
        end
        send_bit(1'b1, 16);
        ticks(4);
        check("t5_vrise", 32'(vrise - v0), 32'd1);
        check("t5_data", 32'(last_d), 32'h0F);

        // Dropping enable mid-frame discards it.
        snap();
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 8);
        enable = 1'b0;
        @(negedge uart_clk);
        check("t6_disabled_idle", 32'(rx_active), 32'd0);
        rx_serial = 1'b1;
        enable    = 1'b1;
        ticks(40);
        check("t6_vrise", 32'(vrise - v0), 32'd0);
        check("t6_fe", 32'(fe_cnt - f0), 32'd0);

        // Async reset in the middle of bit 4, then a clean 0xC8.
        d = 8'hA5;
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(d[i], 16);
        send_bit(d[4], 8);
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", 32'(out_valid), 32'd0);
        check("t7_rst_data", 32'(out_data), 32'd0);
        check("t7_rst_active", 32'(rx_active), 32'd0);
        check("t7_rst_fe", 32'(frame_error), 32'd0);
        check("t7_rst_ov", 32'(overrun_error), 32'd0);
        rx_serial = 1'b1;
        repeat (3) @(negedge uart_clk);
        rst_n = 1'b1;
        ticks(4);
        snap();
        send_frame(8'hC8);
        ticks(8);
        check("t7_vrise", 32'(vrise - v0), 32'd1);
        check("t7_data", 32'(last_d), 32'hC8);
        check("t7_vhigh", 32'(vhigh - h0), 32'd1);

        check("data_stable", 32'(stab_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
